// File: rtl/bit_manipulasyon_pkg.sv
// Shared definitions for the bit-count / byte-manipulation pipeline:
// operation codes, the legal-width check and the count width.
package bit_manipulasyon_pkg;

  // Width of a population / leading / trailing count (values 0..64).
  localparam int CNT_W = 7;

  // Operation codes accepted on din_op_i; anything else yields zero.
  typedef enum logic [3:0] {
    OP_CLZ      = 4'd0,
    OP_CTZ      = 4'd1,
    OP_CPOP     = 4'd2,
    OP_SEXT_B   = 4'd3,
    OP_SEXT_H   = 4'd4,
    OP_ZEXT_H   = 4'd5,
    OP_ORC_B    = 4'd6,
    OP_REV8     = 4'd7,
    OP_BMATFLIP = 4'd8
  } op_e;

  // Datapath widths the pipeline supports.
  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Number of set bits in one byte.
  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

endpackage

// File: rtl/bit_manipulasyon_popcnt.sv
// Combinational population count: per-byte counts summed into a 7-bit total.
module bit_manipulasyon_popcnt
  import bit_manipulasyon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]  din,
  output logic [CNT_W-1:0] cnt
);

  localparam int NB = XLEN / 8;

  logic [3:0] byte_cnt [NB];

  for (genvar g = 0; g < NB; g++) begin : g_byte
    assign byte_cnt[g] = pop8(din[8*g +: 8]);
  end

  // Sum the byte counts into the final total.
  // NOTE: assigning a default before the loop keeps every path driven, so no latch is inferred.
  always_comb begin
    cnt = '0;
    for (int b = 0; b < NB; b++) cnt = cnt + CNT_W'(byte_cnt[b]);
  end

endmodule

// File: rtl/bit_manipulasyon_birim_bitcnt_pipe.sv
// Two-stage bit-count / byte-manipulation pipeline with valid/ready handshake.
// S1 holds the prepared operand, S2 holds the final result.
// Optional macro BITCNT_BMAT_EN adds op 8 (8x8 bit-matrix transpose) when XLEN=64.
module bit_manipulasyon_birim_bitcnt_pipe
  import bit_manipulasyon_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            din_valid_i,
  output logic            din_ready_o,
  input  logic [XLEN-1:0] din_value1_i,
  input  logic [OP_W-1:0] din_op_i,
  input  logic            din_wmode_i,
  output logic            dout_valid_o,
  input  logic            dout_ready_i,
  output logic [XLEN-1:0] dout_result_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("bit_manipulasyon_birim_bitcnt_pipe: XLEN must be 32 or 64");
  end

  localparam logic [XLEN-1:0] LO32 = XLEN'(64'h0000_0000_FFFF_FFFF);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);

  logic            s1_valid, s2_valid, s2_adv;
  logic [OP_W-1:0] s1_op;
  logic [XLEN-1:0] s1_opnd, s2_result;
  logic [XLEN-1:0] src, rev, iso, prep, s2_next;
  logic [CNT_W-1:0] pop_cnt;
  logic            wm;

  assign s2_adv        = !s2_valid || dout_ready_i;
  assign din_ready_o   = !s1_valid || s2_adv;
  assign dout_valid_o  = s2_valid;
  assign dout_result_o = s2_result;

  // A 32-bit datapath is always in word mode.
  assign wm = (XLEN == 32) ? 1'b1 : din_wmode_i;

  // Prepare the S1 operand: counting ops reduce to a popcount in S2.
  always_comb begin
    src = wm ? (din_value1_i & LO32) : din_value1_i;
    rev = '0;
    if (wm) begin
      for (int i = 0; i < 32; i++) rev[i] = src[31-i];
    end else begin
      for (int i = 0; i < XLEN; i++) rev[i] = src[XLEN-1-i];
    end
    iso  = '0;
    prep = din_value1_i;
    case (din_op_i)
      OP_CLZ: begin
        iso  = (rev - ONE) & ~rev;
        prep = wm ? (iso & LO32) : iso;
      end
      OP_CTZ: begin
        iso  = (src - ONE) & ~src;
        prep = wm ? (iso & LO32) : iso;
      end
      OP_CPOP: prep = src;
      default: prep = din_value1_i;
    endcase
  end

  bit_manipulasyon_popcnt #(.XLEN(XLEN)) u_popcnt (
    .din (s1_opnd),
    .cnt (pop_cnt)
  );

`ifdef BITCNT_BMAT_EN
  logic [XLEN-1:0] bmat_res;
  if (XLEN == 64) begin : g_bmat
    // Transpose the operand viewed as an 8x8 bit matrix.
    always_comb begin
      bmat_res = '0;
      for (int i = 0; i < 64; i++) bmat_res[i] = s1_opnd[(i % 8) * 8 + i / 8];
    end
  end else begin : g_no_bmat
    assign bmat_res = '0;
  end
`endif

  // Compute the S2 result from the prepared operand.
  always_comb begin
    s2_next = '0;
    case (s1_op)
      OP_CLZ, OP_CTZ, OP_CPOP: s2_next = XLEN'(pop_cnt);
      OP_SEXT_B: s2_next = {{(XLEN-8){s1_opnd[7]}}, s1_opnd[7:0]};
      OP_SEXT_H: s2_next = {{(XLEN-16){s1_opnd[15]}}, s1_opnd[15:0]};
      OP_ZEXT_H: s2_next = {{(XLEN-16){1'b0}}, s1_opnd[15:0]};
      OP_ORC_B: begin
        for (int b = 0; b < XLEN / 8; b++)
          s2_next[8*b +: 8] = (|s1_opnd[8*b +: 8]) ? 8'hFF : 8'h00;
      end
      OP_REV8: begin
        for (int b = 0; b < XLEN / 8; b++)
          s2_next[8*b +: 8] = s1_opnd[XLEN-8-8*b +: 8];
      end
`ifdef BITCNT_BMAT_EN
      OP_BMATFLIP: s2_next = bmat_res;
`endif
      default: s2_next = '0;
    endcase
  end

  // Pipeline control: stage valids and the visible result.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else begin
      if (din_ready_o) s1_valid <= din_valid_i;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_result <= s2_next;
      end
    end
  end

  // Capture the S1 operand and op code on acceptance.
  // NOTE: these data registers have no reset; s1_valid qualifies them.
  always_ff @(posedge clk_i) begin
    if (din_valid_i && din_ready_o) begin
      s1_op   <= din_op_i;
      s1_opnd <= prep;
    end
  end

endmodule

// File: doc/bit_manipulasyon_birim_bitcnt_pipe.md
BIT_MANIPULASYON_BIRIM_BITCNT_PIPE -- requirements
Module: bit_manipulasyon_birim_bitcnt_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal values 32, 64).
REQ-002 SHALL have parameter OP_W, default 4, width of the operation code.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port din_valid_i, input, 1, operand valid.
REQ-006 SHALL have port din_ready_o, output, 1, operand accepted when high together with din_valid_i.
REQ-007 SHALL have port din_value1_i, input, XLEN, source operand.
REQ-008 SHALL have port din_op_i, input, OP_W, operation code.
REQ-009 SHALL have port din_wmode_i, input, 1, word mode; ignored when XLEN=32, where word mode is forced on.
REQ-010 SHALL have port dout_valid_o, output, 1, result valid.
REQ-011 SHALL have port dout_ready_i, input, 1, consumer ready.
REQ-012 SHALL have port dout_result_o, output, XLEN, result.

Function
REQ-013 SHALL use op codes 0 CLZ, 1 CTZ, 2 CPOP, 3 SEXT.B, 4 SEXT.H, 5 ZEXT.H, 6 ORC.B, 7 REV8, 8 BMATFLIP; all other codes yield result 0.
REQ-014 SHALL be a two-stage pipeline: S1 registers the prepared operand (bit-reversed for CLZ; isolated trailing zeros via (x-1)&~x for CLZ/CTZ; upper 32 bits masked in word mode), and S2 registers the final result.
REQ-015 SHALL have a latency of exactly 2 cycles from the accepting edge to dout_valid_o with no stall, and a throughput of one result per cycle.
REQ-016 SHALL drive din_ready_o = !s1_valid || s2_adv, where s2_adv = !s2_valid || dout_ready_i, combinationally and without a rst_i term.
REQ-017 SHALL hold S2 contents and dout_result_o stable while dout_valid_o=1 and dout_ready_i=0.
REQ-018 SHALL accept a new operand in the same cycle the S2 result is consumed, with no bubble.
REQ-019 SHALL have the CLZ/CTZ result saturate at 32 in word mode and at XLEN otherwise when the operand is 0.
REQ-020 SHALL produce CPOP values up to 64; the count SHALL be 7 bits, zero-extended to XLEN.
REQ-021 SHALL count only bits [31:0] for CLZ/CTZ/CPOP in word mode.
REQ-022 SHALL have ORC.B return, per byte, 0xFF if the byte is nonzero, else 0x00; REV8 SHALL reverse the byte order across XLEN.
REQ-023 SHALL have SEXT/ZEXT ignore din_wmode_i.

Reset
REQ-024 SHALL clear s1_valid and s2_valid on rst_i; dout_valid_o=0 and dout_result_o=0 in the cycle after rst_i is sampled.
REQ-025 SHALL discard in-flight results when rst_i is asserted mid-operation; no result SHALL emerge after reset for an operand accepted before it.
REQ-026 SHALL treat an operand presented during rst_i as not accepted.

Configuration
REQ-027 SHALL compile op 8 BMATFLIP under macro BITCNT_BMAT_EN, active only when XLEN=64: result bit i = operand bit {i[2:0],i[5:3]} (8x8 bit-matrix transpose).
REQ-028 SHALL treat op 8 as an undefined code returning 0 when BITCNT_BMAT_EN is undefined or XLEN=32, and SHALL then instantiate no transpose logic.

Structure
REQ-029 SHALL define the op-code enum, the XLEN-legal check constant and the count width (7) in shared package bit_manipulasyon_pkg.
REQ-030 SHALL implement the popcount as sub-module bit_manipulasyon_popcnt (parameter XLEN, combinational adder tree) used in S2.

Verification
REQ-031 SHALL cover: XLEN=64, CLZ of 0x0000_0000_0000_0001, wmode=0 -> 63 after 2 cycles; wmode=1 -> 31.
REQ-032 SHALL cover: XLEN=32, CTZ of 0 -> 32; CPOP of 0xFFFF_FFFF -> 32; XLEN=64 CPOP of all-ones -> 64.
REQ-033 SHALL cover: back-to-back 4 ops with dout_ready_i=0 for 3 cycles -> din_ready_o low after 2 accepts, results in order, none lost or duplicated.
REQ-034 SHALL cover: SEXT.B 0x80 -> all-ones upper bits ending 0x80; ZEXT.H 0xFFFF_8001 -> 0x8001; ORC.B 0x0001_0000 -> 0x00FF_0000; REV8 0x1122_3344 -> 0x4433_2211.
REQ-035 SHALL cover: rst_i asserted with both stages full -> dout_valid_o=0 the next cycle, no stale result afterwards.
REQ-036 SHALL cover: with BITCNT_BMAT_EN, XLEN=64, BMATFLIP 0x0000_0000_0000_00FF -> 0x0101_0101_0101_0101; without the macro -> 0.
